// File: rtl/decompress_pkg.sv
// -----------------------------------------------------------------------------
// decompress_pkg
// Shared constants, types and helpers for the streaming instruction
// decompressor (decompress_stream) and its output buffer.
//   - word width, token marking, dictionary/descriptor geometry
//   - state_t : expansion FSM states
//   - desc_t  : descriptor table entry {base, lenm1}
//   - is_token(): true when a fetched word is a compressed token
// -----------------------------------------------------------------------------
package decompress_pkg;

   localparam int WIDTH      = 32;
   localparam int ENC_LEN    = 4;
   localparam logic [ENC_LEN-1:0] OPCODE = 4'b1111;
   localparam int TOKEN_BITS = 6;
   localparam int NUM_DESC   = 2 ** TOKEN_BITS;
   localparam int DICT_DEPTH = 256;
   localparam int DICT_AW    = $clog2(DICT_DEPTH);
   localparam int MAX_EXP    = 8;
   localparam int LEN_W      = $clog2(MAX_EXP);
   localparam int FIFO_DEPTH = 4;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      EXPAND = 1'b1
   } state_t;

   // Descriptor entry; packed so it maps 1:1 onto wdata[DICT_AW+LEN_W-1:0].
   typedef struct packed {
      logic [DICT_AW-1:0] base;
      logic [LEN_W-1:0]   lenm1;
   } desc_t;

   function automatic logic is_token(input logic [WIDTH-1:0] word);
      return (word[WIDTH-1 -: ENC_LEN] == OPCODE);
   endfunction

endpackage

// File: rtl/decompress_stream_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO used as the decompressor output buffer. Head entry is
// presented combinationally on dout.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   clr        : synchronous clear (highest priority after reset)
//   push, din  : write request and data (ignored when full unless popping)
//   pop        : read request (ignored when empty)
//   dout       : head entry
//   full/empty : occupancy flags
// -----------------------------------------------------------------------------
module sync_fifo #(
   parameter int WIDTH      = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);

   logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign full  = (r_count == C_FULL);
   assign empty = (r_count == {CW{1'b0}});
   assign dout  = r_mem[r_rptr];

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign w_do_pop  = pop && !empty;
   assign w_do_push = push && (!full || w_do_pop);

   // Pointer and occupancy bookkeeping; pointers wrap naturally at FIFO_DEPTH.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wptr  <= {AW{1'b0}};
         r_rptr  <= {AW{1'b0}};
         r_count <= {CW{1'b0}};
      end else if (clr) begin
         r_wptr  <= {AW{1'b0}};
         r_rptr  <= {AW{1'b0}};
         r_count <= {CW{1'b0}};
      end else begin
         if (w_do_push) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_do_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage array; contents need no reset since occupancy gates visibility.
   always_ff @(posedge clk) begin
      if (w_do_push && !clr) begin
         r_mem[r_wptr] <= din;
      end
   end

endmodule

// File: rtl/decompress_stream.sv
// -----------------------------------------------------------------------------
// decompress_stream
// Streaming instruction decompressor between instruction memory and the CPU
// fetch port. Plain words pass straight into the output FIFO; a token word
// (top ENC_LEN bits == OPCODE) selects a descriptor {base, lenm1} and is
// replaced by dict[base .. base+lenm1] (addresses wrap modulo DICT_DEPTH).
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   flush               : CPU redirect, discards everything in flight
//   in_valid/in_instr/in_ready    : fetch-side handshake
//   out_valid/out_instr/out_ready : CPU-side handshake
//   wme/wsel/waddr/wdata: table write port (wsel 0 = dictionary, 1 = descriptor)
//   busy                : token expansion in progress
// -----------------------------------------------------------------------------
module decompress_stream
   import decompress_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   input  logic               in_valid,
   input  logic [WIDTH-1:0]   in_instr,
   output logic               in_ready,
   output logic               out_valid,
   output logic [WIDTH-1:0]   out_instr,
   input  logic               out_ready,
   input  logic               wme,
   input  logic               wsel,
   input  logic [DICT_AW-1:0] waddr,
   input  logic [WIDTH-1:0]   wdata,
   output logic               busy
);

   logic [WIDTH-1:0] r_dict [DICT_DEPTH];
   desc_t            r_desc [NUM_DESC];

   state_t             r_state;
   logic [DICT_AW-1:0] r_base;
   logic [LEN_W-1:0]   r_lenm1;
   logic [LEN_W-1:0]   r_cnt;

   logic               w_full;
   logic               w_empty;
   logic               w_pop;
   logic               w_push_ok;
   logic               w_accept;
   logic               w_is_tok;
   logic               w_push;
   logic [WIDTH-1:0]   w_din;
   desc_t              w_desc;
   logic [DICT_AW-1:0] w_dict_addr;

   assign out_valid   = !w_empty;
   assign busy        = (r_state == EXPAND);
   assign w_pop       = !w_empty && out_ready;
   assign w_push_ok   = !w_full || w_pop;
   assign in_ready    = (r_state == IDLE) && w_push_ok && !flush;
   assign w_accept    = in_valid && in_ready;
   assign w_is_tok    = is_token(in_instr);
   assign w_desc      = r_desc[in_instr[TOKEN_BITS-1:0]];
   // DICT_AW-bit sum wraps modulo DICT_DEPTH.
   assign w_dict_addr = r_base + DICT_AW'(r_cnt);

   // Table write port; reads are asynchronous so a same-cycle read sees old data.
   always_ff @(posedge clk) begin
      if (wme) begin
         if (wsel) begin
            r_desc[waddr[TOKEN_BITS-1:0]] <= desc_t'(wdata[DICT_AW+LEN_W-1:0]);
         end else begin
            r_dict[waddr] <= wdata;
         end
      end
   end

   // Select what enters the output FIFO this cycle.
   always_comb begin
      w_push = 1'b0;
      w_din  = in_instr;
      case (r_state)
         IDLE: begin
            w_push = w_accept && !w_is_tok;
            w_din  = in_instr;
         end
         EXPAND: begin
            w_push = w_push_ok && !flush;
            w_din  = r_dict[w_dict_addr];
         end
         default: begin
            w_push = 1'b0;
            w_din  = in_instr;
         end
      endcase
   end

   // Expansion FSM: latch descriptor on token accept, step cnt on each push.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_base  <= {DICT_AW{1'b0}};
         r_lenm1 <= {LEN_W{1'b0}};
         r_cnt   <= {LEN_W{1'b0}};
      end else if (flush) begin
         r_state <= IDLE;
         r_cnt   <= {LEN_W{1'b0}};
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept && w_is_tok) begin
                  r_base  <= w_desc.base;
                  r_lenm1 <= w_desc.lenm1;
                  r_cnt   <= {LEN_W{1'b0}};
                  r_state <= EXPAND;
               end
            end
            EXPAND: begin
               if (w_push) begin
                  if (r_cnt == r_lenm1) begin
                     r_cnt   <= {LEN_W{1'b0}};
                     r_state <= IDLE;
                  end else begin
                     r_cnt <= r_cnt + LEN_W'(1);
                  end
               end
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= {LEN_W{1'b0}};
            end
         endcase
      end
   end

   sync_fifo #(
      .WIDTH      (WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_out_fifo (
      .clk   (clk),
      .reset (reset),
      .clr   (flush),
      .push  (w_push),
      .pop   (w_pop),
      .din   (w_din),
      .dout  (out_instr),
      .full  (w_full),
      .empty (w_empty)
   );

endmodule
